// File: rtl/reset_btn_pkg.sv
// reset_btn_pkg: sequencer states and counter width helper shared by the reset/button block.
package reset_btn_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, POR, RUN, BTN_RST} state_t;
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's synchroniser, debounce filter and press/release/long-press pulse logic.
module btn_debounce
  import reset_btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES   = 250000,
  parameter int   LONG_PRESS_CYCLES = 50000000,
  parameter logic ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int LW = cnt_w(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LONG_PRESS_CYCLES);
  logic [1:0] sync_q;
  logic lvl, flip;
  logic [DW-1:0] db_q, db_d;
  logic [LW-1:0] hold_q, hold_d;
  logic btn_q, btn_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
  always_comb begin
    lvl     = sync_q[1] ^ ACTIVE_LOW;
    flip    = (lvl != btn_q) && (db_q == DB_LAST);
    db_d    = (lvl == btn_q || flip) ? '0 : db_q + 1'b1;
    btn_d   = btn_q ^ flip;
    press_d = flip & lvl;
    rel_d   = flip & ~lvl;
    hold_d  = !btn_q ? '0 : (hold_q == LP_MAX) ? hold_q : hold_q + 1'b1;
    long_d  = btn_q && (hold_q == LP_LAST);
  end
  // synchroniser resets to the raw "released" pin level so no phantom edge appears after reset
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {2{ACTIVE_LOW}};
      db_q    <= '0;
      hold_q  <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      db_q    <= db_d;
      hold_q  <= hold_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end
  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
endmodule

// File: rtl/reset_btn_ctrl.sv
// reset_btn_ctrl: PLL-lock qualified power-on reset stretcher with a debounced button bank,
// one button of which can hold the system in reset.
module reset_btn_ctrl
  import reset_btn_pkg::*;
#(
  parameter int                 NUM_BTN           = 7,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW    = 7'b0000001,
  parameter int                 DEBOUNCE_CYCLES   = 250000,
  parameter int                 POR_CYCLES        = 31,
  parameter int                 RESET_BTN         = 0,
  parameter int                 LONG_PRESS_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               pll_locked_i,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic               reset_o,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] long_o
);
  localparam int PW = cnt_w(POR_CYCLES);
  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);
  logic [1:0] lock_q;
  logic rst_btn, reset_q, reset_d;
  logic [PW-1:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (BTN_ACTIVE_LOW[g])
    ) u_db (
      .clk      (clk),
      .rst_i    (reset_i),
      .btn_i    (btn_i[g]),
      .btn_o    (btn_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g])
    );
  end
  // RESET_BTN == NUM_BTN means no button may force reset
  if (RESET_BTN < NUM_BTN) begin : g_rb
    assign rst_btn = btn_o[RESET_BTN];
  end else begin : g_nrb
    assign rst_btn = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    reset_d = (state_q != RUN);
    if (!lock_q[1]) state_d = WAIT_LOCK;
    else begin
      unique case (state_q)
        WAIT_LOCK: state_d = POR;
        POR: begin
          if (rst_btn) state_d = BTN_RST;
          else if (cnt_q == POR_LAST) state_d = RUN;
          else cnt_d = cnt_q + 1'b1;
        end
        RUN:     state_d = rst_btn ? BTN_RST : RUN;
        BTN_RST: state_d = rst_btn ? BTN_RST : POR;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      lock_q  <= 2'b00;
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      reset_q <= 1'b1;
    end else begin
      lock_q  <= {lock_q[0], pll_locked_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
    end
  end
  assign reset_o = reset_q;
endmodule

// File: tb/tb_reset_btn_ctrl.sv
// tb_reset_btn_ctrl: directed sequence with an event scoreboard for reset_btn_ctrl.
module tb_reset_btn_ctrl;
  localparam int NB = 3;
  typedef struct {int kind; int idx; int cyc;} ev_t;
  logic clk = 1'b0;
  logic reset_i, pll_locked_i;
  logic [NB-1:0] btn_i;
  logic reset_o;
  logic [NB-1:0] btn_o, press_o, release_o, long_o;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int c0;
  logic rst_prev = 1'b1;
  ev_t exp_q[$];

  reset_btn_ctrl #(
    .NUM_BTN(NB), .BTN_ACTIVE_LOW(3'b001), .DEBOUNCE_CYCLES(4),
    .POR_CYCLES(8), .RESET_BTN(0), .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk(clk), .reset_i(reset_i), .pll_locked_i(pll_locked_i), .btn_i(btn_i),
    .reset_o(reset_o), .btn_o(btn_o), .press_o(press_o), .release_o(release_o), .long_o(long_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(int k, int i, int c);
    exp_q.push_back('{k, i, c});
  endtask

  // kinds: 0 reset_o rise, 1 reset_o fall, 2 press, 3 release, 4 long
  task automatic sb(int k, int i);
    int e = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].kind == k && exp_q[j].idx == i) begin
        e = exp_q[j].cyc;
        exp_q.delete(j);
        break;
      end
    checks++;
    assert (cyc === e) else begin
      failures++;
      $error("FAIL event kind=%0d idx=%0d observed_cycle=%0d expected_cycle=%0d", k, i, cyc, e);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_o !== rst_prev) sb(reset_o ? 0 : 1, 0);
    rst_prev = reset_o;
    for (int i = 0; i < NB; i++) begin
      if (press_o[i]) sb(2, i);
      if (release_o[i]) sb(3, i);
      if (long_o[i]) sb(4, i);
    end
  end

  initial begin
    reset_i = 1'b1;
    pll_locked_i = 1'b0;
    btn_i = 3'b001;
    tick(3);
    chk("rst_reset_o", 32'(reset_o), 1);
    chk("rst_btn_o", 32'(btn_o), 0);
    chk("rst_press_o", 32'(press_o), 0);
    chk("rst_release_o", 32'(release_o), 0);
    chk("rst_long_o", 32'(long_o), 0);
    reset_i = 1'b0;
    tick(4);
    // power-up after lock
    c0 = cyc;
    pll_locked_i = 1'b1;
    push(1, 0, c0 + 12);
    tick(11);
    chk("por_still_high", 32'(reset_o), 1);
    tick(3);
    chk("por_released", 32'(reset_o), 0);
    // short glitch on btn1
    btn_i[1] = 1'b1;
    tick(3);
    btn_i[1] = 1'b0;
    tick(10);
    chk("glitch_btn1", 32'(btn_o[1]), 0);
    // btn2 long hold, then release together with btn1 press
    c0 = cyc;
    btn_i[2] = 1'b1;
    push(2, 2, c0 + 6);
    push(4, 2, c0 + 26);
    tick(5);
    chk("btn2_before", 32'(btn_o[2]), 0);
    tick(1);
    chk("btn2_after", 32'(btn_o[2]), 1);
    tick(24);
    btn_i[2] = 1'b0;
    btn_i[1] = 1'b1;
    push(3, 2, c0 + 36);
    push(2, 1, c0 + 36);
    tick(10);
    btn_i[1] = 1'b0;
    push(3, 1, c0 + 46);
    tick(10);
    chk("btn_idle", 32'(btn_o), 0);
    chk("run_reset_low", 32'(reset_o), 0);
    // reset button (active low) in RUN
    c0 = cyc;
    btn_i[0] = 1'b0;
    push(2, 0, c0 + 6);
    push(0, 0, c0 + 8);
    tick(10);
    btn_i[0] = 1'b1;
    push(3, 0, c0 + 16);
    push(1, 0, c0 + 26);
    tick(8);
    chk("btnrst_held", 32'(reset_o), 1);
    tick(10);
    chk("btnrst_done", 32'(reset_o), 0);
    // one-cycle lock loss
    c0 = cyc;
    pll_locked_i = 1'b0;
    push(0, 0, c0 + 4);
    push(1, 0, c0 + 13);
    tick(1);
    pll_locked_i = 1'b1;
    tick(3);
    chk("lockloss_reset", 32'(reset_o), 1);
    tick(10);
    chk("relock_run", 32'(reset_o), 0);
    // async reset mid-POR while btn2 is debounced-pressed
    c0 = cyc;
    btn_i[2] = 1'b1;
    push(2, 2, c0 + 6);
    tick(7);
    pll_locked_i = 1'b0;
    push(0, 0, c0 + 11);
    tick(1);
    pll_locked_i = 1'b1;
    tick(5);
    chk("midpor_btn2", 32'(btn_o[2]), 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_reset_o", 32'(reset_o), 1);
    chk("async_btn_o", 32'(btn_o), 0);
    chk("async_pulses", 32'({press_o, release_o, long_o}), 0);
    btn_i[2] = 1'b0;
    tick(2);
    reset_i = 1'b0;
    c0 = cyc;
    push(1, 0, c0 + 12);
    tick(11);
    chk("restart_high", 32'(reset_o), 1);
    tick(2);
    chk("restart_low", 32'(reset_o), 0);
    tick(5);
    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
